// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU op codes and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    // Consumed by the ALU control decoder as well.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: opcode and memory handshake in,
// mux selects, write enables and ALU op out.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal_op
    );

endinterface

// File: rtl/multicycle_control.sv
// Purpose: main sequencing FSM of the multicycle MIPS datapath.
// Latency: Moore outputs from current state; FETCH IR/PC loads follow mem_ready in the same cycle.
// Backpressure: FETCH, MEMRD, MEMWR hold with the memory request high until mem_ready.
module multicycle_control
    import mips_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus,
    output logic [3:0]                  state_o
);

    state_e state_q, state_d;
    // MEMADR must pick lw/sw without looking at the opcode again.
    logic   is_sw_q, is_sw_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    always_comb begin
        state_d           = S_FETCH;
        is_sw_d           = is_sw_q;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.pc_src        = PCSRC_ALU;
        bus.alu_op        = ALUOP_ADD;
        bus.illegal_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.alu_op    = ALUOP_ADD;
                bus.pc_src    = PCSRC_ALU;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMMSH2;
                bus.alu_op    = ALUOP_ADD;
                is_sw_d       = (bus.opcode == OP_SW);
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      bus.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                state_d      = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                state_d       = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_REG;
                bus.alu_op    = ALUOP_FUNCT;
                state_d       = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_src_b     = SRCB_REG;
                bus.alu_op        = ALUOP_SUB;
                bus.pc_src        = PCSRC_ALUOUT;
                bus.pc_write_cond = 1'b1;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
            end
            S_JEX: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase

        // No write may escape while reset is held, even before the clock runs.
        if (!rst_n) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.mem_write     = 1'b0;
            bus.illegal_op    = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: an instruction-level model
// expands each opcode into its expected per-cycle state/control trace.
module tb_multicycle_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] state_o;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
    } cyc_t;

    typedef struct packed {
        logic [3:0] st;
        ctrl_t      c;
    } exp_t;

    cyc_t plan[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %b required %b", name, $time, act[16:0], req[16:0]);
        end
    endtask

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        ctrl_t c = '0;
        case (st)
            4'd0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            4'd1:  begin c.alu_src_b = 2'b11; c.illegal_op = !legal(op); end
            4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd3:  begin c.mem_read = 1; c.iord = 1; end
            4'd4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            4'd5:  begin c.mem_write = 1; c.iord = 1; end
            4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            4'd7:  begin c.reg_write = 1; c.reg_dst = 1; end
            4'd8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_write_cond = 1; end
            4'd9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd10: begin c.reg_write = 1; end
            4'd11: begin c.pc_write = 1; c.pc_src = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t dut_ctrl();
        ctrl_t c;
        c.pc_write      = bus.pc_write;
        c.pc_write_cond = bus.pc_write_cond;
        c.iord          = bus.iord;
        c.mem_read      = bus.mem_read;
        c.mem_write     = bus.mem_write;
        c.ir_write      = bus.ir_write;
        c.mem_to_reg    = bus.mem_to_reg;
        c.reg_dst       = bus.reg_dst;
        c.reg_write     = bus.reg_write;
        c.alu_src_a     = bus.alu_src_a;
        c.alu_src_b     = bus.alu_src_b;
        c.pc_src        = bus.pc_src;
        c.alu_op        = bus.alu_op;
        c.illegal_op    = bus.illegal_op;
        return c;
    endfunction

    // One planned cycle; rdy/op are randomized wherever the DUT must ignore them.
    task automatic push_cyc(input int st, input int rdy, input logic [5:0] op, input logic rnd_op);
        cyc_t        c;
        logic [31:0] r;
        r     = $urandom;
        c.st  = 4'(st);
        c.rdy = (rdy < 0) ? r[0] : rdy[0];
        c.op  = rnd_op ? r[6:1] : op;
        plan.push_back(c);
    endtask

    // wait cycles with the request held, then the completing cycle
    task automatic mem_phase(input int st, input int waits);
        for (int i = 0; i < waits; i++) push_cyc(st, 0, 6'd0, 1'b1);
        push_cyc(st, 1, 6'd0, 1'b1);
    endtask

    task automatic add_instr(input logic [5:0] op, input int wf, input int wm);
        mem_phase(0, wf);
        push_cyc(1, -1, op, 1'b0);
        case (op)
            6'b100011: begin push_cyc(2, -1, 0, 1); mem_phase(3, wm); push_cyc(4, -1, 0, 1); end
            6'b101011: begin push_cyc(2, -1, 0, 1); mem_phase(5, wm); end
            6'b000000: begin push_cyc(6, -1, 0, 1); push_cyc(7, -1, 0, 1); end
            6'b000100: push_cyc(8, -1, 0, 1);
            6'b001000: begin push_cyc(9, -1, 0, 1); push_cyc(10, -1, 0, 1); end
            6'b000010: push_cyc(11, -1, 0, 1);
            default: ;
        endcase
    endtask

    task automatic drive_cycles(input int n);
        for (int i = 0; i < n && plan.size() > 0; i++) begin
            cyc_t c;
            exp_t e;
            c = plan.pop_front();
            @(posedge clk);
            #1;
            bus.mem_ready = c.rdy;
            bus.opcode    = c.op;
            e.st = c.st;
            e.c  = exp_ctrl(c.st, c.rdy, c.op);
            sb.push_back(e);
        end
    endtask

    task automatic chk_reset(input string name);
        ctrl_t r = '0;
        r.mem_read  = 1'b1;
        r.alu_src_b = 2'b01;
        chk({name, "_state"}, 32'(state_o), 32'd0);
        chk({name, "_ctrl"}, 32'(dut_ctrl()), 32'(r));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("state(exp %0d)", e.st), 32'(state_o), 32'(e.st));
                chk($sformatf("ctrl(st %0d)", e.st), 32'(dut_ctrl()), 32'(e.c));
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [5:0]  ops[6];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

        rst_n         = 1'b0;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b1;
        #12;
        chk_reset("reset_hold");
        @(posedge clk);
        #1;
        chk_reset("reset_hold_edge");
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        add_instr(6'b100011, 0, 0);
        add_instr(6'b101011, 0, 3);
        add_instr(6'b000000, 1, 0);
        add_instr(6'b000100, 0, 0);
        add_instr(6'b111111, 0, 0);
        add_instr(6'b000010, 0, 0);
        add_instr(6'b001000, 2, 0);
        drive_cycles(plan.size());

        // reset in the middle of a stalled MEMRD
        add_instr(6'b100011, 0, 5);
        drive_cycles(4);
        @(negedge clk);
        #1;
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset("reset_memrd");
        @(posedge clk);
        #1;
        chk_reset("reset_memrd_edge");
        plan.delete();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        add_instr(6'b001000, 3, 0);
        add_instr(6'b100011, 0, 2);
        drive_cycles(plan.size());

        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            if (r[2:0] < 3'd6) add_instr(ops[r[2:0]], int'(r[4:3]) % 3, int'(r[6:5]));
            else               add_instr(r[12:7], int'(r[4:3]) % 3, int'(r[6:5]));
            drive_cycles(plan.size());
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode from the instruction register and steps fetch, decode, execute, memory and writeback across successive cycles. Each cycle it drives the datapath multiplexer selects and write enables, plus the 2-bit ALU op code consumed by the ALU control decoder (00 add, 01 subtract, 10 use funct field). It stalls on a ready handshake with the shared instruction/data memory.

## Interface
- No parameters; opcode encodings are fixed constants in the shared package.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from instruction register
- mem_ready  in  1  memory completed current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- iord  out  1  memory address select: 0 = PC, 1 = ALU out
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data: 0 = ALU out, 1 = MDR
- reg_dst  out  1  destination: 0 = rt, 1 = rd
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- pc_src  out  2  00 = ALU result, 01 = ALU out register, 10 = jump target
- alu_op  out  2  to ALU control: 00 add, 01 sub, 10 funct
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state_o  out  4  current state encoding, for debug/verification

## Operation
- Moore FSM. Outputs decode from state only, except memory-gated enables noted below. Any signal not listed for a state is 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- FETCH (0): mem_read, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write equal mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE (1): alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode: lw/sw → MEMADR, R → RTYPEEX, beq → BEQEX, addi → ADDIEX, j → JEX. Any other opcode: illegal_op=1, return to FETCH.
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD for lw, MEMWR for sw.
- MEMRD (3): mem_read, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB (4): reg_write, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR (5): mem_write, iord=1. Hold until mem_ready, then FETCH.
- RTYPEEX (6): alu_src_a=1, alu_src_b=00, alu_op=10. Then RTYPEWB.
- RTYPEWB (7): reg_write, reg_dst=1, mem_to_reg=0. Then FETCH.
- BEQEX (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond. Then FETCH.
- ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDIWB.
- ADDIWB (10): reg_write, reg_dst=0, mem_to_reg=0. Then FETCH.
- JEX (11): pc_write, pc_src=10. Then FETCH.
- Encodings 12–15 are unreachable. If entered, the next state is FETCH and outputs are all 0.

## Timing
- Reset (rst_n low, asynchronous): state ← FETCH immediately.
- While rst_n is low, pc_write, pc_write_cond, ir_write, reg_write, mem_write and illegal_op are forced to 0. mem_read=1, alu_src_b=01 and state_o=0 are visible.
- Reset mid-instruction abandons it. No partial writeback occurs after reset asserts.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR, and ignored elsewhere.
- The memory request (mem_read/mem_write) stays high every stall cycle.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2. Each memory wait cycle adds 1.
- The opcode is sampled only in DECODE, one cycle after the IR load. Opcode changes in other states have no effect.

## Structure
- Shared package mips_pkg holds:
  - opcode constants
  - state encodings (4-bit)
  - alu_op codes ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT, shared with the ALU control decoder
  - alu_src_b and pc_src select encodings
- Single module: one state register process and one combinational next-state/output process. No sub-module.

## Test plan
- Reset asserted mid-MEMRD → state_o=0 at once. reg_write is never asserted. After release, FETCH is held until mem_ready.
- lw with mem_ready always 1 → states 0,1,2,3,4,0. reg_write and mem_to_reg are high only in state 4. alu_op=00 throughout.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write high for 4 cycles, iord=1, then FETCH. reg_write is never high.
- R-type then beq → alu_op is 10 in RTYPEEX and 01 in BEQEX. pc_write_cond pulses for exactly 1 cycle, with pc_src=01.
- Opcode 111111 → illegal_op pulses once in DECODE, the next state is FETCH, and no write enable is asserted.
- j and addi back-to-back → JEX shows pc_write=1, pc_src=10. ADDIEX shows alu_src_b=10. ADDIWB shows reg_write=1, reg_dst=0. Total 7 cycles.
